piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer_if.sv | 30 +++
 rtl/piso_serializer.sv | 94 +++++++++
 tb/tb_piso_serializer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// Parallel-in handshake and serial-out bundle for piso_serializer.
// The serializer takes the slave side; the word source and serial sink take the master side.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             so;
    logic             frame;
    logic             last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  so,
        input  frame,
        input  last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output so,
        output frame,
        output last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready intake and registered frame/last strobes.
// A word offered during the last-bit cycle follows with no idle gap.
module piso_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic               clk,
    input logic               reset,
    piso_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             so_q, so_d;
    logic             frame_q, frame_d;
    logic             last_q, last_d;
    logic             at_last, shifting, ready, accept;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign at_last  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign shifting = (state_q == SHIFT) && (cnt_q != CNT_LAST);
    assign ready    = !reset && ((state_q == IDLE) || at_last);
    assign accept   = bus.in_valid && ready;

    // sh_q holds the bits still to be sent; the head bit moves to so_q on each edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        so_d    = so_q;
        frame_d = frame_q;
        last_d  = last_q;
        unique case (1'b1)
            accept: begin
                state_d = SHIFT;
                cnt_d   = '0;
                sh_d    = adv(bus.in_data);
                so_d    = head(bus.in_data);
                frame_d = 1'b1;
                last_d  = 1'b0;
            end
            shifting: begin
                cnt_d   = cnt_q + 1'b1;
                sh_d    = adv(sh_q);
                so_d    = head(sh_q);
                frame_d = 1'b1;
                last_d  = (cnt_q + 1'b1) == CNT_LAST;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                so_d    = IDLE_LEVEL;
                frame_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            so_q    <= IDLE_LEVEL;
            frame_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            so_q    <= so_d;
            frame_q <= frame_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.so       = so_q;
    assign bus.frame    = frame_q;
    assign bus.last     = last_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first, LSB-first and idle-high instances.
// Vectors give inputs for one edge and the outputs expected just after it.
module tb_piso_serializer;
    logic clk;
    logic reset;

    piso_serializer_if #(.WIDTH(8)) ifa ();
    piso_serializer_if #(.WIDTH(8)) ifb ();
    piso_serializer_if #(.WIDTH(8)) ifc ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         r;
        bit         v;
        logic [7:0] d;
        bit         so;
        bit         fr;
        bit         la;
        bit         rdy;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int s, input bit r, input bit v, input logic [7:0] d);
        reset         = r;
        ifa.in_valid  = (s == 0) ? v : 1'b0;
        ifa.in_data   = (s == 0) ? d : 8'h00;
        ifb.in_valid  = (s == 1) ? v : 1'b0;
        ifb.in_data   = (s == 1) ? d : 8'h00;
        ifc.in_valid  = (s == 2) ? v : 1'b0;
        ifc.in_data   = (s == 2) ? d : 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string n, input bit so, input bit fr, input bit la, input bit rdy);
        chk({n, ".so"}, 8'(ifa.so), 8'(so));
        chk({n, ".frame"}, 8'(ifa.frame), 8'(fr));
        chk({n, ".last"}, 8'(ifa.last), 8'(la));
        chk({n, ".ready"}, 8'(ifa.in_ready), 8'(rdy));
    endtask

    vec_t tbl[27];
    logic [7:0] w;

    initial begin
        reset = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        ifb.in_valid = 1'b0; ifb.in_data = '0;
        ifc.in_valid = 1'b0; ifc.in_data = '0;

        // reset, A5 with a held in_valid offering 3C, then FF/00 back-to-back
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 11; i <= 16; i++)
            tbl[i] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 19; i <= 24; i++)
            tbl[i] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[26] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 27; i++) begin
            step(0, tbl[i].r, tbl[i].v, tbl[i].d);
            expect_a($sformatf("vec%0d", i), tbl[i].so, tbl[i].fr, tbl[i].la, tbl[i].rdy);
        end

        // reset during the 4th bit of A5, with in_valid high while in reset
        step(0, 1'b0, 1'b1, 8'hA5);
        expect_a("rst_b1", 1'b1, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00);
        expect_a("rst_b2", 1'b0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00);
        expect_a("rst_b3", 1'b1, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00);
        expect_a("rst_b4", 1'b0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b1, 1'b0, 8'h00);
        expect_a("rst_hi", 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b1, 1'b1, 8'hFF);
        expect_a("rst_prio", 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 8'h00);
        expect_a("rst_rel", 1'b0, 1'b0, 1'b0, 1'b1);
        w = 8'h81;
        step(0, 1'b0, 1'b1, w);
        expect_a("post_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step(0, 1'b0, 1'b0, 8'h00);
            expect_a($sformatf("post_b%0d", i), w[7-i], 1'b1, i == 7, i == 7);
        end
        step(0, 1'b0, 1'b0, 8'h00);
        expect_a("post_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // in_data churns every cycle with in_valid held; C3 then B4 captured
        w = 8'hC3;
        step(0, 1'b0, 1'b1, w);
        expect_a("stab_w0_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step(0, 1'b0, 1'b1, 8'(i * 29 + 7));
            expect_a($sformatf("stab_w0_b%0d", i), w[7-i], 1'b1, i == 7, i == 7);
        end
        w = 8'hB4;
        step(0, 1'b0, 1'b1, w);
        expect_a("stab_w1_b0", 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step(0, 1'b0, 1'b1, 8'(i * 53 + 11));
            expect_a($sformatf("stab_w1_b%0d", i), w[7-i], 1'b1, i == 7, i == 7);
        end
        step(0, 1'b0, 1'b0, 8'h00);
        expect_a("stab_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // LSB-first instance sends 01 as 1 then seven 0s
        step(1, 1'b0, 1'b1, 8'h01);
        chk("lsb_b0.so", 8'(ifb.so), 8'h01);
        chk("lsb_b0.frame", 8'(ifb.frame), 8'h01);
        for (int i = 1; i < 8; i++) begin
            step(1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("lsb_b%0d.so", i), 8'(ifb.so), 8'h00);
            chk($sformatf("lsb_b%0d.last", i), 8'(ifb.last), 8'(i == 7));
        end
        step(1, 1'b0, 1'b0, 8'h00);
        chk("lsb_idle.frame", 8'(ifb.frame), 8'h00);

        // idle-high instance holds so=1 through reset and 20 idle cycles
        step(2, 1'b1, 1'b0, 8'h00);
        chk("idle1_rst.so", 8'(ifc.so), 8'h01);
        chk("idle1_rst.frame", 8'(ifc.frame), 8'h00);
        for (int i = 0; i < 20; i++) begin
            step(2, 1'b0, 1'b0, 8'(i * 13));
            chk($sformatf("idle1_%0d.so", i), 8'(ifc.so), 8'h01);
            chk($sformatf("idle1_%0d.frame", i), 8'(ifc.frame), 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
